// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage: sequential fetch from a handshaked memory into a
// DEPTH-entry FIFO, credit-limited, with redirect flush and stale-response discard.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

  state_t        state;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] count, inflight, discard;
  logic [CW-1:0] count_n, inflight_n, total_n;
  logic [31:0]   resp_pc;
  logic [31:0]   head_instr_n, head_pc_n;
  logic          flush, grant, drop, push, pop;

  always_comb begin
    flush      = redirect & (state != BOOT);
    grant      = mem_req & mem_gnt;
    drop       = mem_rvalid & (discard != {CW{1'b0}});
    push       = mem_rvalid & ~drop & ~flush;
    pop        = instr_valid & instr_ready & ~flush;
    rd_ptr_n   = rd_ptr + PW'(pop);
    count_n    = count + CW'(push) - CW'(pop);
    inflight_n = inflight + CW'(grant) - CW'(mem_rvalid);
    total_n    = (flush ? {CW{1'b0}} : count_n) + inflight_n;
    // When the pushed word becomes the only entry, forward it straight to the head.
    if ((count - CW'(pop)) == {CW{1'b0}}) begin
      head_instr_n = mem_rdata;
      head_pc_n    = resp_pc;
    end else begin
      head_instr_n = data_mem[rd_ptr_n];
      head_pc_n    = pc_mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      resp_pc     <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      count       <= '0;
      inflight    <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= inflight_n;
      if (flush) begin
        // Everything still outstanding belongs to the old stream.
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        instr_valid <= 1'b0;
        discard     <= inflight_n;
        mem_addr    <= redirect_pc & ~32'd3;
        resp_pc     <= redirect_pc & ~32'd3;
      end else begin
        count       <= count_n;
        rd_ptr      <= rd_ptr_n;
        wr_ptr      <= wr_ptr + PW'(push);
        instr_valid <= (count_n != {CW{1'b0}});
        if (drop) discard <= discard - CW'(1);
        if (grant) mem_addr <= mem_addr + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (count_n != {CW{1'b0}}) begin
          instr    <= head_instr_n;
          instr_pc <= head_pc_n;
        end
      end

      case (state)
        BOOT: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH, FULL: begin
          if (total_n == CW'(DEPTH)) begin
            state   <= FULL;
            mem_req <= 1'b0;
          end else begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= BOOT;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: behavioural memory with per-stream epoch
// tags, expected-instruction scoreboard queue, redirect vector table and corner sequences.
module tb_ifetch_prefetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } resp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] first;
    logic [31:0] second;
  } vec_t;

  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dlog[$];
  vec_t        vecs[5];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          grants = 0;
  int          first_valid = -1;
  logic        gnt_en = 1'b1;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] a0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dlog(input string name, input int idx, input logic [31:0] exp);
    if (idx < dlog.size()) check(name, dlog[idx], exp);
    else begin
      checks++;
      failures++;
      $display("FAIL %s: got no delivery #%0d expected %h", name, idx, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
  endtask

  task automatic clear_model();
    resp_q.delete();
    exp_q.delete();
    dlog.delete();
    epoch++;
    exp_addr    = 32'h0;
    first_valid = -1;
    grants      = 0;
    mem_rvalid  = 1'b0;
    redirect    = 1'b0;
  endtask

  // Called at posedge+1; drives this cycle's memory inputs, observes mid-cycle.
  task automatic cycle();
    resp_t r;
    mem_gnt    = gnt_en;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = resp_q[0].addr ^ 32'hA5A5_0000;
    end
    #3;
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (mem_req && mem_gnt) begin
      check("grant_addr", mem_addr, exp_addr);
      resp_q.push_back('{mem_addr, cyc + lat, epoch});
      grants++;
      exp_addr = exp_addr + 32'd4;
    end
    if (mem_rvalid) begin
      r = resp_q.pop_front();
      if (r.epoch == epoch && !redirect) exp_q.push_back(r.addr);
    end
    if (instr_valid && instr_ready && !redirect) begin
      dlog.push_back(instr_pc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got pc %h expected none (cycle %0d)", instr_pc, cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("deliver_pc", instr_pc, e);
        check("deliver_instr", instr, e ^ 32'hA5A5_0000);
      end
    end
    if (redirect) begin
      exp_q.delete();
      dlog.delete();
      epoch++;
      exp_addr = redirect_pc & ~32'd3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
    vecs[3] = '{32'h0000_0556, 32'h0000_0554, 32'h0000_0558};
    vecs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};

    #1;
    check_reset_outputs("reset");

    // Streaming from reset: first head in cycle 3, then one per cycle.
    do_reset();
    lat = 1; gnt_en = 1'b1; instr_ready = 1'b1;
    run(13);
    check("first_valid_cycle", 32'(first_valid), 32'd3);
    check("stream_count", 32'(dlog.size()), 32'd10);
    check_dlog("stream_pc0", 0, 32'h0);
    check_dlog("stream_pc9", 9, 32'h24);

    // Back-pressure: four grants then FULL; drain resumes at 0x10.
    do_reset();
    lat = 1; gnt_en = 1'b1; instr_ready = 1'b0;
    run(12);
    check("full_grants", 32'(grants), 32'd4);
    check("full_mem_req", 32'(mem_req), 32'h0);
    check("full_head_valid", 32'(instr_valid), 32'h1);
    dlog.delete();
    instr_ready = 1'b1;
    run(10);
    check_dlog("drain_pc0", 0, 32'h0);
    check_dlog("drain_pc1", 1, 32'h4);
    check_dlog("drain_pc2", 2, 32'h8);
    check_dlog("drain_pc3", 3, 32'hC);
    check_dlog("drain_pc4", 4, 32'h10);
    check_dlog("drain_pc5", 5, 32'h14);

    // Redirect with two responses in flight on a 3-cycle memory.
    do_reset();
    lat = 3; gnt_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (resp_q.size() == 2) break;
      cycle();
    end
    check("t3_two_inflight", 32'(resp_q.size()), 32'd2);
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0; gnt_en = 1'b1;
    run(15);
    check_dlog("t3_pc0", 0, 32'h100);
    check_dlog("t3_pc1", 1, 32'h104);

    // Redirect vector table, each coincident with rvalid, pop and grant.
    do_reset();
    lat = 1; gnt_en = 1'b1; instr_ready = 1'b1;
    run(6);
    for (int v = 0; v < 5; v++) begin
      check("vec_coincident", 32'(mem_req && instr_valid && resp_q.size() > 0), 32'h1);
      redirect = 1'b1; redirect_pc = vecs[v].target;
      cycle();
      redirect = 1'b0;
      check("vec_flush_valid", 32'(instr_valid), 32'h0);
      check("vec_mem_addr", mem_addr, vecs[v].first);
      run(6);
      check_dlog("vec_first_pc", 0, vecs[v].first);
      check_dlog("vec_second_pc", 1, vecs[v].second);
    end

    // Back-to-back redirects: latest wins.
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect_pc = 32'h400;
    cycle();
    redirect = 1'b0;
    run(8);
    check_dlog("b2b_pc0", 0, 32'h400);
    check_dlog("b2b_pc1", 1, 32'h404);

    // Grant stall: request and address hold, then advance by one word.
    gnt_en = 1'b0;
    a0 = exp_addr;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_req", 32'(mem_req), 32'h1);
      check("stall_addr", mem_addr, a0);
    end
    gnt_en = 1'b1;
    cycle();
    check("stall_release_addr", mem_addr, a0 + 32'd4);
    run(4);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    lat = 2; gnt_en = 1'b1; instr_ready = 1'b0;
    run(6);
    check("pre_reset_valid", 32'(instr_valid), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    instr_ready = 1'b1;
    run(10);
    check("post_reset_first_valid", 32'(first_valid), 32'd4);
    check_dlog("post_reset_pc0", 0, 32'h0);
    check_dlog("post_reset_pc1", 1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
